// File: rtl/tck_burst_gen.sv
// TAP burst driver: turns a one-clock active-low start strobe into N TCK
// cycles, shifting tdi_word out LSB-first while capturing TDO into the same
// register, with TMS raised only on the final bit and a one-cycle done pulse.
module tck_burst_gen #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_n,
  input  logic [LEN_W-1:0]  bit_count,
  input  logic [DATA_W-1:0] tdi_word,
  input  logic              tms_last,
  input  logic [DIV_W-1:0]  half_period,
  input  logic              tdo,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  output logic [DATA_W-1:0] tdo_word,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FIN} state_t;

  state_t            state;
  logic              start_n_q;
  logic [DATA_W-1:0] sr;
  logic [LEN_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  phase;
  logic [DIV_W-1:0]  h_lat;
  logic              tms_l;

  logic              start;
  logic [DIV_W-1:0]  h_eff;

  // Falling-edge detect on the strobe; zero half period behaves as one.
  always_comb begin
    start = ~start_n & start_n_q;
    h_eff = (half_period == '0) ? DIV_W'(1) : half_period;
  end

  // Burst sequencer: phase counter times each TCK half, bit counter counts
  // down the remaining bits; all pin outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_n_q <= 1'b1;
      sr        <= '0;
      bit_cnt   <= '0;
      phase     <= '0;
      h_lat     <= DIV_W'(1);
      tms_l     <= 1'b0;
      tck       <= 1'b0;
      tms       <= 1'b0;
      tdi       <= 1'b0;
      tdo_word  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_n_q <= start_n;
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (bit_count == '0) begin
              // Empty burst: just acknowledge, leave tdo_word alone.
              done  <= 1'b1;
              state <= FIN;
            end else begin
              sr      <= tdi_word;
              bit_cnt <= bit_count;
              h_lat   <= h_eff;
              phase   <= h_eff - DIV_W'(1);
              tms_l   <= tms_last;
              busy    <= 1'b1;
              tck     <= 1'b0;
              tdi     <= tdi_word[0];
              tms     <= (bit_count == LEN_W'(1)) ? tms_last : 1'b0;
              state   <= LOW;
            end
          end
        end
        LOW: begin
          if (phase == '0) begin
            // Rising TCK: capture TDO into the top, shift toward the LSB.
            tck   <= 1'b1;
            sr    <= {tdo, sr[DATA_W-1:1]};
            phase <= h_lat - DIV_W'(1);
            state <= HIGH;
          end else begin
            phase <= phase - DIV_W'(1);
          end
        end
        HIGH: begin
          if (phase == '0) begin
            tck <= 1'b0;
            if (bit_cnt > LEN_W'(1)) begin
              bit_cnt <= bit_cnt - LEN_W'(1);
              tdi     <= sr[0];
              tms     <= (bit_cnt == LEN_W'(2)) ? tms_l : 1'b0;
              phase   <= h_lat - DIV_W'(1);
              state   <= LOW;
            end else begin
              bit_cnt  <= '0;
              tdi      <= 1'b0;
              tms      <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              tdo_word <= sr;
              state    <= FIN;
            end
          end else begin
            phase <= phase - DIV_W'(1);
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
